// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO controller driving an external two-port RAM with 1-cycle read latency
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clear_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_addr_0,
    output logic                  ram_ce_0,
    output logic                  ram_wr_0,
    output logic [DATA_WIDTH-1:0] ram_data_0,
    output logic [ADDR_WIDTH-1:0] ram_addr_1,
    output logic                  ram_ce_1,
    output logic                  ram_wr_1,
    input  logic [DATA_WIDTH-1:0] ram_data_1,
    output logic                  ram_rst_n,
    output logic                  ram_full
);

    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_acc, rd_acc;

    // Extra wrap bit distinguishes full (same slot, different lap) from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign wr_acc = wr_en & ~full  & ~flush & ~rst;
    assign rd_acc = rd_en & ~empty & ~flush & ~rst;

    assign ram_ce_0   = wr_acc;
    assign ram_wr_0   = wr_acc;
    assign ram_addr_0 = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_0 = wr_data;
    assign ram_ce_1   = rd_acc;
    assign ram_wr_1   = 1'b0;
    assign ram_addr_1 = rd_ptr_q[ADDR_WIDTH-1:0];
    assign ram_rst_n  = ~rst;
    assign ram_full   = full;

    assign rd_data      = ram_data_1;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_acc;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Error set wins over a simultaneous clear; a flush cycle never sets them.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full && !flush)  overflow_d  = 1'b1;
        if (rd_en && empty && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - randomized self-checking bench for fifo_ctrl against a queue model
module tb_fifo_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, flush, clear_err, wr_en, rd_en;
    logic [7:0] wr_data, rd_data, ram_data_0, ram_data_1;
    logic       rd_valid, full, empty, almost_full, almost_empty;
    logic [2:0] count;
    logic       overflow, underflow;
    logic [1:0] ram_addr_0, ram_addr_1;
    logic       ram_ce_0, ram_wr_0, ram_ce_1, ram_wr_1, ram_rst_n, ram_full;

    logic [7:0] mem [DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    int         wcnt, rcnt;
    bit         m_valid, m_ovf, m_udf;
    logic [7:0] m_rdata;

    always #5 clk = ~clk;

    fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .clear_err(clear_err),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_addr_0(ram_addr_0), .ram_ce_0(ram_ce_0), .ram_wr_0(ram_wr_0), .ram_data_0(ram_data_0),
        .ram_addr_1(ram_addr_1), .ram_ce_1(ram_ce_1), .ram_wr_1(ram_wr_1), .ram_data_1(ram_data_1),
        .ram_rst_n(ram_rst_n), .ram_full(ram_full)
    );

    // Synchronous RAM with registered read data
    always @(posedge clk) begin
        if (ram_ce_0 && ram_wr_0) mem[ram_addr_0] <= ram_data_0;
        if (ram_ce_1) ram_data_1 <= mem[ram_addr_1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0;
        m_valid = 0; m_ovf = 0; m_udf = 0;
    endtask

    // One clock: drive after posedge, check at negedge, advance model at posedge.
    task automatic step(input bit wr, input logic [7:0] wd, input bit rd,
                        input bit fl = 0, input bit ce = 0, input bit rs = 0);
        bit f_e, e_e, wacc, racc;
        wr_en = wr; wr_data = wd; rd_en = rd; flush = fl; clear_err = ce; rst = rs;
        f_e  = (q.size() == DEPTH);
        e_e  = (q.size() == 0);
        wacc = wr && !f_e && !fl && !rs;
        racc = rd && !e_e && !fl && !rs;
        @(negedge clk);
        check("ce0", 32'(ram_ce_0), 32'(wacc));
        check("wr0", 32'(ram_wr_0), 32'(wacc));
        check("addr0", 32'(ram_addr_0), 32'(wcnt % DEPTH));
        check("data0", 32'(ram_data_0), 32'(wd));
        check("ce1", 32'(ram_ce_1), 32'(racc));
        check("wr1", 32'(ram_wr_1), 32'd0);
        check("addr1", 32'(ram_addr_1), 32'(rcnt % DEPTH));
        check("full", 32'(full), 32'(f_e));
        check("ram_full", 32'(ram_full), 32'(f_e));
        check("empty", 32'(empty), 32'(e_e));
        check("count", 32'(count), 32'(q.size()));
        check("afull", 32'(almost_full), 32'(q.size() >= 3));
        check("aempty", 32'(almost_empty), 32'(q.size() <= 1));
        check("valid", 32'(rd_valid), 32'(m_valid));
        if (m_valid) check("rdata", 32'(rd_data), 32'(m_rdata));
        check("ovf", 32'(overflow), 32'(m_ovf));
        check("udf", 32'(underflow), 32'(m_udf));
        check("rstn", 32'(ram_rst_n), 32'(!rs));
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            if (ce) begin m_ovf = 0; m_udf = 0; end
            if (!fl) begin
                if (wr && f_e) m_ovf = 1;
                if (rd && e_e) m_udf = 1;
            end
            if (fl) begin
                q.delete(); wcnt = 0; rcnt = 0; m_valid = 0;
            end else begin
                m_valid = racc;
                if (racc) begin m_rdata = q.pop_front(); rcnt++; end
                if (wacc) begin q.push_back(wd); wcnt++; end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; clear_err = 0; wr_en = 0; rd_en = 0; wr_data = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0);

        // Fill, overflow, clear
        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
        step(1, 8'h55, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 1);
        // Drain, underflow
        repeat (4) step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0, 0, 1);

        // Wrap-around with interleaving
        for (int i = 0; i < 8; i++) step(i < 6, 8'hA0 + 8'(i), i >= 2);
        step(0, 8'h00, 0);

        // Simultaneous read/write at count 2, full, empty
        step(1, 8'hB0, 0); step(1, 8'hB1, 0);
        step(1, 8'hB2, 1);
        step(1, 8'hB3, 0); step(1, 8'hB4, 0);
        step(1, 8'hB5, 1);
        repeat (3) step(0, 8'h00, 1);
        step(1, 8'hB6, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0, 0, 1);

        // Flush with pending read data, then reset mid-write
        repeat (4) step(1, 8'hC0, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0, 1);
        step(0, 8'h00, 0);
        step(1, 8'hD0, 0); step(1, 8'hD1, 1);
        step(1, 8'hD2, 0, 0, 0, 1);
        step(0, 8'h00, 0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 79) == 0);
        end
        step(0, 8'h00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width; depth DEPTH = 2^ADDR_WIDTH.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold.
REQ-005 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pointer/count clear
- clear_err  in  1  clears sticky error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  read data, valid when rd_valid=1
- rd_valid  out  1  rd_data qualifier
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  ADDR_WIDTH+1  stored word count, 0..DEPTH
- overflow, underflow  out  1 each  sticky error flags
- ram_addr_0  out  ADDR_WIDTH  RAM write address
- ram_ce_0, ram_wr_0  out  1 each  RAM port-0 enable and write select
- ram_data_0  out  DATA_WIDTH  RAM write data
- ram_addr_1  out  ADDR_WIDTH  RAM read address
- ram_ce_1, ram_wr_1  out  1 each  RAM port-1 enable and write select (ram_wr_1 tied 0)
- ram_data_1  in  DATA_WIDTH  RAM registered read data (1-cycle latency)
- ram_rst_n  out  1  RAM reset, equals ~rst
- ram_full  out  1  equals full

Function
REQ-006 SHALL keep wr_ptr and rd_ptr of ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address RAM, MSB is wrap bit.
REQ-007 SHALL define wr_acc = wr_en & ~full and rd_acc = rd_en & ~empty, evaluated from current registered state.
REQ-008 SHALL drive ram_ce_0 = ram_wr_0 = wr_acc, ram_addr_0 = wr_ptr[ADDR_WIDTH-1:0], ram_data_0 = wr_data, combinationally.
REQ-009 SHALL drive ram_ce_1 = rd_acc, ram_addr_1 = rd_ptr[ADDR_WIDTH-1:0], combinationally.
REQ-010 SHALL increment wr_ptr on wr_acc and rd_ptr on rd_acc at the same edge, modulo 2^(ADDR_WIDTH+1).
REQ-011 SHALL register rd_valid = rd_acc, so rd_valid asserts exactly one cycle after an accepted read; rd_data = ram_data_1 passthrough.
REQ-012 SHALL assert empty when wr_ptr == rd_ptr; full when low bits equal and MSBs differ.
REQ-013 SHALL keep count registered: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-014 SHALL assert almost_full when count >= AF_LEVEL, almost_empty when count <= AE_LEVEL.
REQ-015 SHALL reject a write when full even if rd_en is simultaneously accepted; SHALL reject a read when empty even if wr_en is simultaneously asserted.
REQ-016 SHALL set overflow on wr_en & full, underflow on rd_en & empty; both hold until clear_err or rst; set has priority over simultaneous clear_err.
REQ-017 SHALL, on flush, zero wr_ptr, rd_ptr, count and rd_valid next edge, suppress wr_acc/rd_acc that cycle, leave error flags unchanged.
REQ-018 SHALL not alter RAM contents on flush; stale data is unreachable through pointers.

Reset
REQ-019 SHALL, while rst=1 at a rising edge, clear wr_ptr, rd_ptr, count, rd_valid, overflow, underflow; after reset empty=1, almost_empty=1, full=0, almost_full=0.
REQ-020 SHALL force ram_ce_0 = ram_ce_1 = 0 while rst=1; ram_rst_n = 0 while rst=1.
REQ-021 SHALL give rst priority over flush, clear_err, wr_en, rd_en; reset mid-transfer discards all in-flight state including a pending rd_valid.

Verification (ADDR_WIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-022 Reset then write 0x11,0x22,0x33,0x44 on 4 cycles -> count 1,2,3,4; almost_full at count 3; full=1 after 4th; ram_addr_0 0,1,2,3.
REQ-023 Fifth write 0x55 while full -> ram_ce_0=0, count stays 4, overflow=1 and holds; clear_err -> overflow=0.
REQ-024 Read 4 words -> rd_valid one cycle after each rd_en, rd_data 0x11,0x22,0x33,0x44; empty=1 after last; extra rd_en -> underflow=1, ram_ce_1=0.
REQ-025 Write 6 then read 6 interleaved -> pointers wrap past address 3 to 0, data order preserved, full never asserted falsely.
REQ-026 At count 2, wr_en & rd_en same cycle -> both accepted, count stays 2; at full, both -> only read accepted, count 3; at empty, both -> only write accepted, count 1.
REQ-027 flush at count 3 with pending rd_valid -> next cycle count 0, empty=1, rd_valid=0, error flags unchanged; rst during writes -> all outputs at reset values next cycle.
